// File: rtl/battle_pkg.sv
// Shared battle-screen definitions: FSM encoding, screen limits, damage type.
package battle_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_LATCH  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam int H_LAST    = 639;
    localparam int V_LAST    = 479;
    localparam int DMG_W_DEF = 7;

    typedef logic [DMG_W_DEF-1:0] damage_t;

endpackage

// File: rtl/meter_grade.sv
// Combinational zone grader: marker centre -> 3x / 2x / 1x damage, saturating.
module meter_grade #(
    parameter int X_CENTRE = 300,
    parameter int ZONE3_HW = 10,
    parameter int ZONE2_HW = 40,
    parameter int BASE_DMG = 15,
    parameter int DMG_W    = 7
) (
    input  logic [10:0]      c,
    output logic [DMG_W-1:0] dmg
);

    logic [10:0] d;
    logic [15:0] prod;

    // Distance from the zone centre, then multiplier and saturation to the output width.
    always_comb begin
        d    = (c >= 11'(X_CENTRE)) ? (c - 11'(X_CENTRE)) : (11'(X_CENTRE) - c);
        prod = 16'(BASE_DMG);
        if (d <= 11'(ZONE3_HW))
            prod = 16'(3 * BASE_DMG);
        else if (d <= 11'(ZONE2_HW))
            prod = 16'(2 * BASE_DMG);
        if (prod > 16'((1 << DMG_W) - 1))
            dmg = '1;
        else
            dmg = prod[DMG_W-1:0];
    end

endmodule

// File: rtl/pangya_meter.sv
// Timing-bar attack meter: sweeping marker, press latch, zone grading,
// valid/ack result handshake and marker pixel flag for the VGA mixer.
module pangya_meter
    import battle_pkg::*;
#(
    parameter int X_MIN      = 220,
    parameter int X_MAX      = 376,
    parameter int X_START    = 295,
    parameter int X_CENTRE   = 300,
    parameter int Y_TOP      = 290,
    parameter int MARK_W     = 5,
    parameter int MARK_H     = 30,
    parameter int STEP       = 6,
    parameter int FRAME_DIV  = 3,
    parameter int ZONE3_HW   = 10,
    parameter int ZONE2_HW   = 40,
    parameter int BASE_DMG   = 15,
    parameter int DMG_W      = 7,
    parameter int MAX_BOUNCE = 4
) (
    input  logic             Pclk,
    input  logic             rst,
    input  logic [9:0]       xx,
    input  logic [9:0]       yy,
    input  logic             aactive,
    input  logic             arm,
    input  logic             press,
    output logic             marker_on,
    output logic             attack_valid,
    input  logic             attack_ack,
    output logic [DMG_W-1:0] damage,
    output logic             miss
);

    state_t           state, state_n;
    logic [9:0]       mx, mx_mv;
    logic             dir, dir_mv;      // 1 = moving right
    logic [7:0]       frame_cnt;
    logic [7:0]       bounce_cnt;
    logic             frame_tick, bounce_hit, flip;
    logic [10:0]      centre;
    logic [DMG_W-1:0] grade_dmg;

    assign frame_tick = (xx == 10'(H_LAST)) && (yy == 10'(V_LAST));
    assign bounce_hit = (MAX_BOUNCE != 0) && (bounce_cnt == 8'(MAX_BOUNCE));
    assign centre     = {1'b0, mx} + 11'(MARK_W / 2);

    meter_grade #(
        .X_CENTRE (X_CENTRE),
        .ZONE3_HW (ZONE3_HW),
        .ZONE2_HW (ZONE2_HW),
        .BASE_DMG (BASE_DMG),
        .DMG_W    (DMG_W)
    ) u_grade (
        .c   (centre),
        .dmg (grade_dmg)
    );

    // Candidate marker position for the next move tick, clamped at the sweep bounds.
    always_comb begin
        mx_mv  = mx;
        dir_mv = dir;
        flip   = 1'b0;
        if (dir) begin
            if ({1'b0, mx} + 11'(STEP) > 11'(X_MAX)) begin
                mx_mv  = 10'(X_MAX);
                dir_mv = 1'b0;
                flip   = 1'b1;
            end else begin
                mx_mv = mx + 10'(STEP);
            end
        end else begin
            if ({1'b0, mx} < 11'(X_MIN + STEP)) begin
                mx_mv  = 10'(X_MIN);
                dir_mv = 1'b1;
                flip   = 1'b1;
            end else begin
                mx_mv = mx - 10'(STEP);
            end
        end
    end

    // Next-state logic; press wins over auto-miss and over a same-cycle move.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (arm) state_n = S_SWEEP;
            S_SWEEP:  if (press || bounce_hit) state_n = S_LATCH;
            S_LATCH:  state_n = S_REPORT;
            S_REPORT: if (attack_ack && attack_valid) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Pclk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Marker motion, counters and the attack result registers.
    always_ff @(posedge Pclk) begin
        if (rst) begin
            mx           <= 10'(X_START);
            dir          <= 1'b1;
            frame_cnt    <= '0;
            bounce_cnt   <= '0;
            attack_valid <= 1'b0;
            damage       <= '0;
            miss         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (arm) begin
                    mx         <= 10'(X_START);
                    dir        <= 1'b1;
                    frame_cnt  <= '0;
                    bounce_cnt <= '0;
                end
                S_SWEEP: if (!press) begin
                    if (bounce_hit) begin
                        miss <= 1'b1;
                    end else if (frame_tick) begin
                        if (frame_cnt == 8'(FRAME_DIV - 1)) begin
                            frame_cnt <= '0;
                            mx        <= mx_mv;
                            dir       <= dir_mv;
                            if (flip) bounce_cnt <= bounce_cnt + 8'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_LATCH: begin
                    damage       <= miss ? '0 : grade_dmg;
                    attack_valid <= 1'b1;
                end
                S_REPORT: if (attack_ack && attack_valid) begin
                    attack_valid <= 1'b0;
                    miss         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Registered marker pixel flag, one cycle behind the raster inputs.
    always_ff @(posedge Pclk) begin
        if (rst) begin
            marker_on <= 1'b0;
        end else begin
            marker_on <= aactive && (state != S_IDLE)
                      && ({1'b0, xx} >= {1'b0, mx})
                      && ({1'b0, xx} <  {1'b0, mx} + 11'(MARK_W))
                      && (yy >= 10'(Y_TOP))
                      && ({1'b0, yy} <  11'(Y_TOP + MARK_H));
        end
    end

endmodule

// File: tb/tb_pangya_meter.sv
// Directed bench for pangya_meter; a second instance starts at mx=308 so the
// zone edges (c=310, c=340) are reachable on the 6 px step grid.
module tb_pangya_meter;
    import battle_pkg::*;

    logic       Pclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] xx = '0, yy = '0;
    logic       aactive = 1'b0;
    logic       arm = 1'b0, press = 1'b0, attack_ack = 1'b0;
    logic       arm_b = 1'b0, press_b = 1'b0, ack_b = 1'b0;
    logic       marker_on, attack_valid, miss;
    logic       marker_on_b, valid_b, miss_b;
    damage_t    damage, damage_b;

    int checks = 0;
    int errors = 0;

    always #20 Pclk = ~Pclk;

    pangya_meter dut (
        .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
        .arm(arm), .press(press), .marker_on(marker_on),
        .attack_valid(attack_valid), .attack_ack(attack_ack),
        .damage(damage), .miss(miss)
    );

    pangya_meter #(.X_START(308)) dut_b (
        .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
        .arm(arm_b), .press(press_b), .marker_on(marker_on_b),
        .attack_valid(valid_b), .attack_ack(ack_b),
        .damage(damage_b), .miss(miss_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Pclk);
        #1;
    endtask

    // n consecutive cycles with the raster parked on the last pixel: one frame tick each.
    task automatic frames(input int n);
        xx = 10'd639; yy = 10'd479;
        repeat (n) step();
        xx = 10'd0; yy = 10'd0;
    endtask

    task automatic do_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_valid", 32'(attack_valid), 0);
        chk("rst_damage", 32'(damage), 0);
        chk("rst_miss", 32'(miss), 0);
        chk("rst_marker", 32'(marker_on), 0);
        chk("rst_mx", 32'(dut.mx), 295);
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));

        // Perfect hit: 14 ticks right to the clamp, 13 back left -> mx=298, c=300
        do_arm();
        chk("arm_state", 32'(dut.state), 32'(S_SWEEP));
        attack_ack = 1'b1; step(); attack_ack = 1'b0;
        chk("ack_ignored", 32'(dut.state), 32'(S_SWEEP));
        frames(81);
        chk("mx_298", 32'(dut.mx), 298);
        press = 1'b1; step(); press = 1'b0;
        chk("lat_valid_n1", 32'(attack_valid), 0);
        chk("lat_state", 32'(dut.state), 32'(S_LATCH));
        step();
        chk("c300_valid", 32'(attack_valid), 1);
        chk("c300_dmg", 32'(damage), 45);
        chk("c300_miss", 32'(miss), 0);
        repeat (3) step();
        chk("hold_valid", 32'(attack_valid), 1);
        chk("hold_dmg", 32'(damage), 45);
        attack_ack = 1'b1; step(); attack_ack = 1'b0;
        chk("ack_valid", 32'(attack_valid), 0);
        chk("ack_state", 32'(dut.state), 32'(S_IDLE));

        // c=330 -> 2x
        do_arm();
        frames(66);
        chk("mx_328", 32'(dut.mx), 328);
        press = 1'b1; step(); press = 1'b0; step();
        chk("c330_dmg", 32'(damage), 30);
        attack_ack = 1'b1; step(); attack_ack = 1'b0;

        // c=345 -> 1x, then arm in REPORT ignored, then reset mid-REPORT
        do_arm();
        frames(24);
        chk("mx_343", 32'(dut.mx), 343);
        press = 1'b1; step(); press = 1'b0; step();
        chk("c345_dmg", 32'(damage), 15);
        do_arm();
        chk("armrep_state", 32'(dut.state), 32'(S_REPORT));
        chk("armrep_valid", 32'(attack_valid), 1);
        chk("armrep_mx", 32'(dut.mx), 343);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_valid", 32'(attack_valid), 0);
        chk("midrst_dmg", 32'(damage), 0);
        chk("midrst_mx", 32'(dut.mx), 295);
        chk("midrst_state", 32'(dut.state), 32'(S_IDLE));

        // Free sweep: moves every 3rd frame, clamps, auto-miss after 4 reversals
        do_arm();
        frames(2);
        chk("sw_f2", 32'(dut.mx), 295);
        frames(1);
        chk("sw_f3", 32'(dut.mx), 301);
        frames(38);
        chk("sw_t13", 32'(dut.mx), 373);
        frames(1);
        chk("sw_clamp_hi", 32'(dut.mx), 376);
        frames(81);
        chk("sw_clamp_lo", 32'(dut.mx), 220);
        chk("sw_state", 32'(dut.state), 32'(S_SWEEP));
        frames(81);
        chk("sw_clamp_hi2", 32'(dut.mx), 376);
        chk("sw_no_valid", 32'(attack_valid), 0);
        frames(81);
        chk("sw_clamp_lo2", 32'(dut.mx), 220);
        step();
        chk("am_state", 32'(dut.state), 32'(S_LATCH));
        step();
        chk("am_valid", 32'(attack_valid), 1);
        chk("am_miss", 32'(miss), 1);
        chk("am_dmg", 32'(damage), 0);
        attack_ack = 1'b1; step(); attack_ack = 1'b0;
        chk("am_ack_miss", 32'(miss), 0);
        chk("am_ack_state", 32'(dut.state), 32'(S_IDLE));

        // Press on a move tick: graded on pre-tick mx=308 (c=310 -> 45, moved would give 30)
        arm_b = 1'b1; step(); arm_b = 1'b0;
        frames(2);
        xx = 10'd639; yy = 10'd479; press_b = 1'b1;
        step();
        xx = 10'd0; yy = 10'd0; press_b = 1'b0;
        chk("pt_mx", 32'(dut_b.mx), 308);
        chk("pt_state", 32'(dut_b.state), 32'(S_LATCH));
        step();
        chk("c310_dmg", 32'(damage_b), 45);
        chk("c310_valid", 32'(valid_b), 1);
        ack_b = 1'b1; step(); ack_b = 1'b0;

        // c=340 -> 2x edge
        arm_b = 1'b1; step(); arm_b = 1'b0;
        frames(15);
        chk("mx_338", 32'(dut_b.mx), 338);
        press_b = 1'b1; step(); press_b = 1'b0; step();
        chk("c340_dmg", 32'(damage_b), 30);
        ack_b = 1'b1; step(); ack_b = 1'b0;

        // Marker pixel: off in IDLE, 5x30 box at (295,290) while sweeping
        aactive = 1'b1; xx = 10'd297; yy = 10'd300;
        step();
        chk("mk_idle", 32'(marker_on), 0);
        do_arm();
        for (int y = 286; y < 324; y++) begin
            for (int x = 291; x < 304; x++) begin
                xx = 10'(x); yy = 10'(y);
                step();
                chk("mk_scan", 32'(marker_on),
                    32'((x >= 295 && x < 300 && y >= 290 && y < 320) ? 1 : 0));
            end
        end
        xx = 10'd296; yy = 10'd300;
        step();
        chk("mk_on", 32'(marker_on), 1);
        xx = 10'd0; yy = 10'd0;
        #1;
        chk("mk_delay", 32'(marker_on), 1);
        step();
        chk("mk_off", 32'(marker_on), 0);
        aactive = 1'b0; xx = 10'd296; yy = 10'd300;
        step();
        chk("mk_blank", 32'(marker_on), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
